fpmul_operand_feeder: RTL and testbench
=======================================

# fpmul_operand_feeder

Upstream buffering stage for the single-precision FP multiplier wrapper. Accepts IEEE-754 binary32 operand pairs (A, B) from a stimulus source or producer over a valid/ready handshake. Stores them in a small FIFO and presents them one pair at a time to the multiplier wrapper's input port. This decouples producer bursts from the multiplier's one-pair-in-flight handshake.

## Interface
Parameters:
- DEPTH, 4: number of operand-pair entries. Power of two, minimum 2.

Ports:
- clk  input  1  clock. All state updates on its rising edge.
- rst  input  1  reset. Asynchronous, active-high.
- flush  input  1  synchronous clear of FIFO contents.
- in_valid  input  1  producer offers a pair.
- in_ready  output  1  feeder can accept a pair.
- in_a  input  32  operand A, binary32.
- in_b  input  32  operand B, binary32.
- out_valid  output  1  head pair available to the multiplier wrapper.
- out_ready  input  1  multiplier wrapper's ready.
- out_a  output  32  head operand A.
- out_b  output  32  head operand B.
- count  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
- special  output  1  head pair contains an Inf/NaN operand (exponent field 8'hFF in either operand). Valid only while out_valid is high.

## Operation
- Push: a pair is written when in_valid && in_ready at a rising edge. It is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop: the head pair is consumed when out_valid && out_ready at a rising edge. The read pointer increments modulo DEPTH.
- Count update per edge: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- in_ready = (count != DEPTH).
  - No write-through when full: a pop in the same cycle does not enable a push.
- out_valid = (count != 0).
- out_a, out_b and special are read from storage at the read pointer.
- While out_valid && !out_ready, out_a, out_b and special hold stable.
- The producer must hold in_a/in_b stable while in_valid && !in_ready. The feeder does not check this.
- Flush at an edge: pointers and count go to 0. Flush takes priority over any push or pop in the same cycle; such a push or pop is discarded. Storage contents are don't-care.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- Reset values, asserted asynchronously at any time including mid-transfer:
  - count = 0, in_ready = 1, out_valid = 0, special = 0.
  - out_a and out_b are don't-care while out_valid = 0.
  - Pointers = 0.

## Timing
- Latency: a pair pushed at edge N appears on out_* with out_valid high after edge N. The earliest it can be consumed is edge N+1.
- in_ready and out_valid are derived only from the registered count. There is no combinational path from in_valid or out_ready to either.
- Throughput: one push and one pop per cycle. The multiplier wrapper deasserts ready while it computes, so sustained rate is set downstream.
- Full, with out_ready high: the pop frees an entry, and in_ready rises after that edge.
- Empty, with in_valid high: the push occurs and out_valid rises after that edge. A same-edge pop is impossible.
- Release of rst takes effect asynchronously. The first push can occur at the first rising edge with rst low.

## Configuration
- FEEDER_DENORM_FLUSH_EN defined: on push, each operand with exponent == 0 and mantissa != 0 is replaced by a signed zero (sign bit kept, bits [30:0] = 0). The replacement is stored in the FIFO, so out_a/out_b carry the flushed values.
- FEEDER_DENORM_FLUSH_EN undefined: operands are stored and presented bit-exact.
- special is computed on the stored value in both builds.

## Structure
- Package fpmul_feeder_pkg:
  - typedef operand_pair_t, a packed struct {logic [31:0] a; logic [31:0] b;}.
  - Constants EXP_MSB = 30, EXP_LSB = 23, EXP_ALL_ONES = 8'hFF.
  - Functions is_special(logic [31:0]) and flush_denorm(logic [31:0]).
- Sub-module feeder_fifo: a generic DEPTH-entry operand_pair_t FIFO containing pointers, count and storage. The top level adds the handshake mapping, the denormal flush and the special flag.

## Test plan
- Reset then single pair: push A=32'h3FC00000 (1.5), B=32'h40000000 (2.0) with out_ready low → out_valid=1 after one edge, out_a/out_b match, count=1, special=0. Raise out_ready → count=0, out_valid=0.
- Fill to full (DEPTH=4): push 4 pairs with out_ready=0 → count=4, in_ready=0. A fifth offer is held, not written. Pop one → in_ready=1 next cycle, and output order equals push order.
- Simultaneous push and pop at count=2 → count stays 2. Pop 6 pairs through wrap → all values correct and in order.
- Special flag: push A=32'h7F800000 (+Inf), B=32'h3F800000 → special=1 while that pair is head. Push A=32'h7FC00000 (NaN) → special=1.
- Flush and reset: flush asserted in the same cycle as a push at count=3 → count=0, out_valid=0, pushed pair dropped. rst pulsed asynchronously between edges while count=2 → count=0 and in_ready=1 immediately.
- Denormal: push A=32'h80000001, B=32'h00400000 → with FEEDER_DENORM_FLUSH_EN, out_a=32'h80000000 and out_b=32'h00000000; without it, both values unchanged.

Source files
------------

// File: rtl/fpmul_feeder_pkg.sv
// Shared types and binary32 field helpers for the FP multiplier operand feeder.
package fpmul_feeder_pkg;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } operand_pair_t;

   localparam int          EXP_MSB      = 30;
   localparam int          EXP_LSB      = 23;
   localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;

   function automatic logic is_special(input logic [31:0] v);
      return v[EXP_MSB:EXP_LSB] == EXP_ALL_ONES;
   endfunction

   // Subnormals collapse to a zero of the same sign.
   function automatic logic [31:0] flush_denorm(input logic [31:0] v);
      if (v[EXP_MSB:EXP_LSB] == 8'h00 && v[EXP_LSB-1:0] != '0)
         return {v[31], 31'b0};
      return v;
   endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Generic DEPTH-entry operand-pair FIFO: storage, wrapping pointers and occupancy count.
module feeder_fifo
   import fpmul_feeder_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr_en,
   input  operand_pair_t            wr_data,
   input  logic                     rd_en,
   output operand_pair_t            rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   operand_pair_t   mem [DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [CW-1:0]   cnt;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign rd_data = mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (wr_en) wptr <= wptr + AW'(1);
         if (rd_en) rptr <= rptr + AW'(1);
         if (wr_en && !rd_en)      cnt <= cnt + CW'(1);
         else if (rd_en && !wr_en) cnt <= cnt - CW'(1);
      end
   end

   // Storage needs no reset; entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (wr_en && !flush) mem[wptr] <= wr_data;
   end

endmodule

// File: rtl/fpmul_operand_feeder.sv
// Operand-pair buffer in front of the FP multiplier wrapper.
// Optional build macro FEEDER_DENORM_FLUSH_EN flushes subnormal operands to signed zero on push.
module fpmul_operand_feeder
   import fpmul_feeder_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_a,
   input  logic [31:0]              in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_a,
   output logic [31:0]              out_b,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     special
);

   operand_pair_t wdata, head;
   logic          full, empty, push, pop;

   // Handshakes depend only on registered occupancy, so a full FIFO never writes through.
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

`ifdef FEEDER_DENORM_FLUSH_EN
   assign wdata = '{a: flush_denorm(in_a), b: flush_denorm(in_b)};
`else
   assign wdata = '{a: in_a, b: in_b};
`endif

   feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .wr_en   (push),
      .wr_data (wdata),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign out_a   = head.a;
   assign out_b   = head.b;
   assign special = out_valid && (is_special(head.a) || is_special(head.b));

endmodule

// File: tb/tb_fpmul_operand_feeder.sv
// Directed bench for fpmul_operand_feeder with a queue-based reference model.
module tb_fpmul_operand_feeder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0, in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_a, out_b;
   logic [2:0]  count;
   logic        special;

   int nchk = 0;
   int nfail = 0;

   fpmul_operand_feeder #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .count(count), .special(special)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_flush(input logic [31:0] v);
`ifdef FEEDER_DENORM_FLUSH_EN
      if (((v >> 23) & 32'hFF) == 0 && (v & 32'h007F_FFFF) != 0) return v & 32'h8000_0000;
`endif
      return v;
   endfunction

   function automatic logic m_special(input logic [31:0] v);
      return ((v >> 23) & 32'hFF) == 32'hFF;
   endfunction

   // Reference model: a plain queue of pairs.
   logic [31:0] qa[$], qb[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         qa.delete(); qb.delete();
      end else if (flush) begin
         qa.delete(); qb.delete();
      end else begin
         bit do_push, do_pop;
         do_push = in_valid && (qa.size() < DEPTH);
         do_pop  = out_ready && (qa.size() > 0);
         if (do_pop) begin
            void'(qa.pop_front()); void'(qb.pop_front());
         end
         if (do_push) begin
            qa.push_back(m_flush(in_a)); qb.push_back(m_flush(in_b));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("m_count", 32'(count), 32'(qa.size()));
         chk("m_in_ready", 32'(in_ready), 32'(qa.size() != DEPTH));
         chk("m_out_valid", 32'(out_valid), 32'(qa.size() != 0));
         if (qa.size() > 0) begin
            chk("m_out_a", out_a, qa[0]);
            chk("m_out_b", out_b, qb[0]);
            chk("m_special", 32'(special), 32'(m_special(qa[0]) || m_special(qb[0])));
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic rdy);
      in_valid = v; in_a = a; in_b = b; out_ready = rdy;
   endtask

   initial begin
      // Reset state, checked while rst is still high.
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_special", 32'(special), 0);
      #11 rst = 1'b0;
      step();

      // Single pair.
      drive(1, 32'h3FC00000, 32'h40000000, 0); step();
      chk("single_valid", 32'(out_valid), 1);
      chk("single_a", out_a, 32'h3FC00000);
      chk("single_b", out_b, 32'h40000000);
      chk("single_count", 32'(count), 1);
      chk("single_special", 32'(special), 0);
      drive(0, 0, 0, 1); step();
      chk("single_pop_count", 32'(count), 0);
      chk("single_pop_valid", 32'(out_valid), 0);

      // Fill to full, hold a fifth offer, then pop without write-through.
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h3F800000 + i, 32'h40400000 + i, 0); step();
      end
      chk("full_count", 32'(count), 4);
      chk("full_in_ready", 32'(in_ready), 0);
      drive(1, 32'h41000000, 32'h41100000, 0); step();
      chk("held_count", 32'(count), 4);
      chk("full_head_a", out_a, 32'h3F800000);
      out_ready = 1; step();
      chk("nowt_count", 32'(count), 3);
      chk("nowt_in_ready", 32'(in_ready), 1);
      chk("order_a", out_a, 32'h3F800001);
      step();  // fifth pair enters with a simultaneous pop
      chk("pp_count3", 32'(count), 3);
      drive(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step();
      chk("drained", 32'(count), 0);

      // Simultaneous push/pop at count 2, then traffic through pointer wrap.
      drive(1, 32'h42000000, 32'h42100000, 0); step();
      drive(1, 32'h42200000, 32'h42300000, 0); step();
      drive(1, 32'h42400000, 32'h42500000, 1); step();
      chk("pp_count2", 32'(count), 2);
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h43000000 + 32'(i * 3), 32'h44000000 + 32'(i * 5), 1); step();
      end
      drive(0, 0, 0, 1); step(); step();
      chk("wrap_empty", 32'(count), 0);

      // Special operands.
      drive(1, 32'h7F800000, 32'h3F800000, 0); step();
      chk("inf_special", 32'(special), 1);
      drive(0, 0, 0, 1); step();
      drive(1, 32'h7FC00000, 32'h3F800000, 0); step();
      chk("nan_special", 32'(special), 1);
      drive(0, 0, 0, 1); step();

      // Flush beats a same-cycle push.
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h45000000 + i, 32'h46000000 + i, 0); step();
      end
      drive(1, 32'h47000000, 32'h47100000, 0); flush = 1; step();
      flush = 0; drive(0, 0, 0, 0);
      chk("flush_count", 32'(count), 0);
      chk("flush_valid", 32'(out_valid), 0);

      // Asynchronous reset between edges at count 2.
      drive(1, 32'h48000000, 32'h48100000, 0); step(); step();
      drive(0, 0, 0, 0);
      chk("pre_rst_count", 32'(count), 2);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_in_ready", 32'(in_ready), 1);
      chk("arst_out_valid", 32'(out_valid), 0);
      #1 rst = 1'b0;
      step();

      // Subnormal operands.
      drive(1, 32'h80000001, 32'h00400000, 0); step();
`ifdef FEEDER_DENORM_FLUSH_EN
      chk("denorm_a", out_a, 32'h80000000);
      chk("denorm_b", out_b, 32'h00000000);
`else
      chk("denorm_a", out_a, 32'h80000001);
      chk("denorm_b", out_b, 32'h00400000);
`endif
      drive(0, 0, 0, 1); step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
